// File: rtl/color_bar_gen.sv
// Test-pattern generator: vertical bars, horizontal bars, checkerboard or scrolling bars, registered RGB.
// Define COLOR_BAR_SCROLL_EN to build the scroll offset logic; otherwise mode 3 renders as vertical bars.
module color_bar_gen #(
  parameter int unsigned HVID        = 640,
  parameter int unsigned VVID        = 480,
  parameter int unsigned NUM_BARS    = 8,
  parameter int unsigned COLOR_W     = 8,
  parameter int unsigned SCROLL_STEP = 16
) (
  input  logic               clk_25,
  input  logic               rst,
  input  logic [9:0]         horizontal_num,
  input  logic [9:0]         vertical_num,
  input  logic               video_on,
  input  logic               frame_start,
  input  logic [1:0]         mode_in,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic [1:0]         mode_active
);

  typedef enum logic [1:0] {
    MODE_VBARS   = 2'd0,
    MODE_HBARS   = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_SCROLL  = 2'd3
  } mode_t;

  localparam logic [10:0] BAR_W  = 11'(HVID / NUM_BARS);
  localparam logic [10:0] BAR_H  = 11'(VVID / NUM_BARS);
  localparam logic [10:0] HVID_W = 11'(HVID);
  localparam logic [10:0] VVID_W = 11'(VVID);
  localparam logic [2:0]  LAST   = 3'(NUM_BARS - 1);

  // Remainder pixels past the last full bar fold into the last bar.
  function automatic logic [2:0] bar_idx(input logic [10:0] coord, input logic [10:0] size);
    logic [10:0] q;
    q = coord / size;
    return (q > {8'd0, LAST}) ? LAST : 3'(q);
  endfunction

  function automatic logic [3*COLOR_W-1:0] palette(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return {{COLOR_W{m[2]}}, {COLOR_W{m[1]}}, {COLOR_W{m[0]}}};
  endfunction

  mode_t                mode_q;
  logic [10:0]          h_ext;
  logic [10:0]          v_ext;
  logic [2:0]           h_idx;
  logic [2:0]           v_idx;
  logic [2:0]           x_idx;
  logic [2:0]           pix_idx;
  logic                 in_active;
  logic [3*COLOR_W-1:0] pix_rgb;

  assign h_ext       = {1'b0, horizontal_num};
  assign v_ext       = {1'b0, vertical_num};
  assign h_idx       = bar_idx(h_ext, BAR_W);
  assign v_idx       = bar_idx(v_ext, BAR_H);
  assign mode_active = mode_q;

`ifdef COLOR_BAR_SCROLL_EN
  logic [9:0]  offset;
  logic [10:0] xs_sum;
  logic [10:0] xs;
  logic [10:0] off_sum;
  logic [10:0] off_next;

  // Sums kept at 11 bits so the wrap compare sees the true value.
  always_comb begin
    xs_sum   = h_ext + {1'b0, offset};
    xs       = (xs_sum >= HVID_W) ? xs_sum - HVID_W : xs_sum;
    off_sum  = {1'b0, offset} + 11'(SCROLL_STEP);
    off_next = (off_sum >= HVID_W) ? off_sum - HVID_W : off_sum;
  end

  assign x_idx = bar_idx(xs, BAR_W);

  always_ff @(posedge clk_25) begin
    if (rst) begin
      offset <= '0;
    end else if (frame_start) begin
      offset <= (mode_t'(mode_in) == MODE_SCROLL) ? 10'(off_next) : '0;
    end
  end
`else
  assign x_idx = h_idx;
`endif

  always_comb begin
    in_active = video_on && (h_ext < HVID_W) && (v_ext < VVID_W);
    pix_idx   = h_idx;
    case (mode_q)
      MODE_HBARS:   pix_idx = v_idx;
      MODE_CHECKER: pix_idx = (h_idx[0] ^ v_idx[0]) ? LAST : 3'd0;
      MODE_SCROLL:  pix_idx = x_idx;
      default:      pix_idx = h_idx;
    endcase
    pix_rgb = in_active ? palette(pix_idx) : '0;
  end

  // The pixel uses the pre-edge mode/offset even if frame_start lands in active video.
  always_ff @(posedge clk_25) begin
    if (rst) begin
      {red, green, blue} <= '0;
      mode_q             <= MODE_VBARS;
    end else begin
      {red, green, blue} <= pix_rgb;
      if (frame_start) begin
        mode_q <= mode_t'(mode_in);
      end
    end
  end

endmodule

// File: tb/tb_color_bar_gen.sv
// Scoreboard bench for color_bar_gen: directed vectors push expected RGB/mode, a monitor pops and compares.
module tb_color_bar_gen;

`ifdef COLOR_BAR_SCROLL_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  localparam logic [23:0] W = 24'hFFFFFF;
  localparam logic [23:0] Y = 24'hFFFF00;
  localparam logic [23:0] C = 24'h00FFFF;
  localparam logic [23:0] R = 24'hFF0000;
  localparam logic [23:0] K = 24'h000000;

  logic       clk_25 = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] horizontal_num = '0;
  logic [9:0] vertical_num = '0;
  logic       video_on = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] mode_in = '0;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [1:0] mode_active;

  color_bar_gen #(
    .HVID(640), .VVID(480), .NUM_BARS(8), .COLOR_W(8), .SCROLL_STEP(16)
  ) dut (
    .clk_25(clk_25), .rst(rst),
    .horizontal_num(horizontal_num), .vertical_num(vertical_num),
    .video_on(video_on), .frame_start(frame_start), .mode_in(mode_in),
    .red(red), .green(green), .blue(blue), .mode_active(mode_active)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    string       name;
    logic [23:0] rgb;
    logic [1:0]  mode;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   issue = 1'b0;

  task automatic drive(input logic r, input logic [1:0] m, input logic fs, input logic von,
                       input int hh, input int vv, input bit chk, input string name,
                       input logic [23:0] ergb, input logic [1:0] emode);
    exp_t e;
    @(negedge clk_25);
    rst            = r;
    mode_in        = m;
    frame_start    = fs;
    video_on       = von;
    horizontal_num = 10'(hh);
    vertical_num   = 10'(vv);
    if (chk) begin
      e.name = name;
      e.rgb  = ergb;
      e.mode = emode;
      sb.push_back(e);
    end
    issue = chk;
  endtask

  task automatic ck(input string name, input logic r, input logic [1:0] m, input logic fs,
                    input logic von, input int hh, input int vv,
                    input logic [23:0] ergb, input logic [1:0] emode);
    drive(r, m, fs, von, hh, vv, 1'b1, name, ergb, emode);
  endtask

  task automatic st(input logic r, input logic [1:0] m, input logic fs, input logic von,
                    input int hh, input int vv);
    drive(r, m, fs, von, hh, vv, 1'b0, "", '0, '0);
  endtask

  task automatic frame(input logic [1:0] m);
    st(1'b0, m, 1'b1, 1'b0, 0, 500);
  endtask

  always @(posedge clk_25) begin
    if (issue) begin
      #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if ({red, green, blue} !== mon_e.rgb) begin
          errors++;
          $display("FAIL %s rgb: got %06h expected %06h", mon_e.name, {red, green, blue}, mon_e.rgb);
        end
        checks++;
        if (mode_active !== mon_e.mode) begin
          errors++;
          $display("FAIL %s mode_active: got %0d expected %0d", mon_e.name, mode_active, mon_e.mode);
        end
      end
    end
  end

  initial begin
    ck("reset",        1, 0, 0, 1,   0,   0, K, 0);
    ck("vbar_h0",      0, 0, 0, 1,   0,   0, W, 0);
    ck("vbar_h80",     0, 0, 0, 1,  80,   0, Y, 0);
    ck("vbar_h639",    0, 0, 0, 1, 639,   0, K, 0);
    ck("vbar_h160",    0, 0, 0, 1, 160,   0, C, 0);
    ck("vbar_h400",    0, 0, 0, 1, 400,   0, R, 0);
    ck("blank_von",    0, 0, 0, 0, 100,   0, K, 0);
    ck("blank_h650",   0, 0, 0, 1, 650,   0, K, 0);
    ck("blank_v480",   0, 0, 0, 1,   0, 480, K, 0);
    ck("mode_hold1",   0, 1, 0, 1,   0,  60, W, 0);
    ck("mode_hold2",   0, 1, 0, 1,  80,  60, Y, 0);
    ck("fs_to_hbar",   0, 1, 1, 0,   0, 500, K, 1);
    ck("hbar_v60",     0, 1, 0, 1,   0,  60, Y, 1);
    ck("hbar_v479",    0, 1, 0, 1,   0, 479, K, 1);
    ck("hbar_v300",    0, 1, 0, 1,   0, 300, R, 1);
    ck("fs_video_on",  0, 2, 1, 1,   0, 120, C, 2);
    ck("chk_0_0",      0, 2, 0, 1,   0,   0, W, 2);
    ck("chk_80_0",     0, 2, 0, 1,  80,   0, K, 2);
    ck("chk_80_60",    0, 2, 0, 1,  80,  60, W, 2);
    ck("chk_639_479",  0, 2, 0, 1, 639, 479, W, 2);
    ck("fs_to_scroll", 0, 3, 1, 0,   0, 500, K, 3);
    for (int i = 0; i < 4; i++) frame(3);
    ck("scroll_h0",    0, 3, 0, 1,   0,   0, SC ? Y : W, 3);
    ck("scroll_h600",  0, 3, 0, 1, 600,   0, SC ? W : K, 3);
    ck("scroll_h560",  0, 3, 0, 1, 560,   0, SC ? W : K, 3);
    for (int i = 0; i < 34; i++) frame(3);
    ck("scroll_off624",   0, 3, 0, 1,  0, 0, SC ? K : W, 3);
    ck("scroll_wrap_h16", 0, 3, 0, 1, 16, 0, W, 3);
    frame(3);
    ck("scroll_off0",     0, 3, 0, 1, 80, 0, Y, 3);
    frame(3);
    ck("scroll_off16",    0, 3, 0, 1, 70, 0, SC ? Y : W, 3);
    ck("fs_to_vbar",      0, 0, 1, 0,  0, 500, K, 0);
    ck("vbar_after_scr",  0, 0, 0, 1,  0, 0, W, 0);
    ck("fs_back_scroll",  0, 3, 1, 0,  0, 500, K, 3);
    ck("scroll_cleared",  0, 3, 0, 1, 60, 0, W, 3);
    ck("scroll_cleared2", 0, 3, 0, 1, 70, 0, SC ? Y : W, 3);
    frame(3);
    ck("scroll_off32",    0, 3, 0, 1, 50, 0, SC ? Y : W, 3);
    ck("rst_mid",         1, 3, 0, 1, 80, 0, K, 0);
    ck("post_rst_mode",   0, 3, 0, 1, 70, 0, W, 0);
    ck("fs_after_rst",    0, 3, 1, 0,  0, 500, K, 3);
    ck("offset_reset",    0, 3, 0, 1, 60, 0, W, 3);
    ck("offset_reset2",   0, 3, 0, 1, 70, 0, SC ? Y : W, 3);
    st(0, 3, 0, 0, 0, 0);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk_25);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
